// File: rtl/otp_pkg.sv
// otp_pkg: shared types and constants for the OTP authenticator.
// FSM state enum, LFSR seed/taps and the hex 7-segment table.
package otp_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ENTRY,
        CHECK,
        LOCK
    } state_t;

    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    // {g,f,e,d,c,b,a}, active-high
    localparam logic [6:0] SEG7_LUT [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F,
        7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C,
        7'h39, 7'h5E, 7'h79, 7'h71
    };

endpackage

// File: rtl/otp_seg7_dec.sv
// otp_seg7_dec: combinational hex digit to 7-segment decoder.
// Ports: digit (4b hex in), seg (7b {g..a} active-high out).
module otp_seg7_dec
    import otp_pkg::*;
(
    input  logic [3:0] digit,
    output logic [6:0] seg
);

    assign seg = SEG7_LUT[digit];

endmodule

// File: rtl/otp_auth_multi.sv
// otp_auth_multi: N-digit OTP authenticator with retry limit, lockout and
// multiplexed 7-seg display of the OTP and the user entry.
// Ports: clk, reset (sync, active-high), otp_latch/user_latch (rising-edge
// events), user_in (digit), lfsr_out/user_out (7-seg), an (one-hot anode),
// auth_pass/auth_fail (1-cycle pulses), locked, tries_left.
// Optional: define OTP_TIMEOUT_EN to fail an entry left idle too long.
module otp_auth_multi
    import otp_pkg::*;
#(
    parameter int NUM_DIGITS     = 4,
    parameter int DIGIT_W        = 4,
    parameter int LFSR_W         = 16,
    parameter int MAX_TRIES      = 3,
    parameter int LOCK_CYCLES    = 1024,
    parameter int SCAN_DIV       = 16,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           otp_latch,
    input  logic                           user_latch,
    input  logic [DIGIT_W-1:0]             user_in,
    output logic [6:0]                     lfsr_out,
    output logic [6:0]                     user_out,
    output logic [NUM_DIGITS-1:0]          an,
    output logic                           auth_pass,
    output logic                           auth_fail,
    output logic                           locked,
    output logic [$clog2(MAX_TRIES+1)-1:0] tries_left
);

    localparam int CW = NUM_DIGITS * DIGIT_W;
    localparam int NW = $clog2(NUM_DIGITS + 1);
    localparam int IW = $clog2(NUM_DIGITS);
    localparam int TW = $clog2(MAX_TRIES + 1);
    localparam int LW = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;
    localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [LFSR_W-1:0] TAPS = LFSR_W'(LFSR_TAPS);

    if (NUM_DIGITS < 2 || NUM_DIGITS > 8) begin : g_bad_nd
        $error("NUM_DIGITS must be 2..8");
    end
    if (DIGIT_W != 4) begin : g_bad_dw
        $error("DIGIT_W must be 4");
    end
    if (LFSR_W < CW) begin : g_bad_lw
        $error("LFSR_W too narrow for the code");
    end
    if (MAX_TRIES < 1) begin : g_bad_mt
        $error("MAX_TRIES must be >= 1");
    end
    if (TIMEOUT_CYCLES < 2) begin : g_bad_to
        $error("TIMEOUT_CYCLES must be >= 2");
    end

    state_t state, state_d;

    logic [LFSR_W-1:0]                   lfsr;
    logic                                otp_q, usr_q;
    logic                                otp_ev, usr_ev;
    logic [NUM_DIGITS-1:0][DIGIT_W-1:0]  otp, entry;
    logic                                otp_valid;
    logic [NW-1:0]                       cnt;
    logic [LW-1:0]                       lock_cnt;
    logic                                lock_done;
    logic [SW-1:0]                       scan_cnt;
    logic [IW-1:0]                       idx;
    logic [6:0]                          otp_seg, usr_seg;
    logic                                match, to_hit;
    logic                                cap, take, clr, miss;
    logic                                pass_d, inval;
    logic [TW-1:0]                       tries_d;

    assign otp_ev    = otp_latch & ~otp_q;
    assign usr_ev    = user_latch & ~usr_q;
    assign match     = (entry == otp);
    assign lock_done = (lock_cnt == LW'(LOCK_CYCLES - 1));

`ifdef OTP_TIMEOUT_EN
    localparam int TOW = $clog2(TIMEOUT_CYCLES);
    logic [TOW-1:0] to_cnt;

    always_ff @(posedge clk) begin
        if (reset || state != ENTRY || otp_ev || usr_ev || to_hit)
            to_cnt <= '0;
        else
            to_cnt <= to_cnt + TOW'(1);
    end

    assign to_hit = (state == ENTRY) &&
                    (to_cnt == TOW'(TIMEOUT_CYCLES - 1));
`else
    assign to_hit = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_d;
    end

    always_comb begin
        state_d = state;
        cap     = 1'b0;
        take    = 1'b0;
        clr     = 1'b0;
        miss    = 1'b0;
        pass_d  = 1'b0;
        inval   = 1'b0;
        tries_d = tries_left;
        unique case (state)
            IDLE: begin
                if (otp_ev) begin
                    cap     = 1'b1;
                    state_d = ENTRY;
                end
            end
            ENTRY: begin
                // a fresh OTP always beats a digit in the same cycle
                if (otp_ev) begin
                    cap = 1'b1;
                end else if (usr_ev) begin
                    take = 1'b1;
                    if (cnt == NW'(NUM_DIGITS - 1))
                        state_d = CHECK;
                end else if (to_hit) begin
                    miss = 1'b1;
                end
            end
            CHECK: begin
                if (match) begin
                    pass_d  = 1'b1;
                    inval   = 1'b1;
                    tries_d = TW'(MAX_TRIES);
                    state_d = IDLE;
                end else begin
                    miss = 1'b1;
                end
            end
            LOCK: begin
                if (lock_done) begin
                    inval   = 1'b1;
                    tries_d = TW'(MAX_TRIES);
                    state_d = IDLE;
                end
            end
            default: ;
        endcase
        if (miss) begin
            tries_d = tries_left - TW'(1);
            if (tries_left == TW'(1)) begin
                state_d = LOCK;
            end else begin
                clr     = 1'b1;
                state_d = ENTRY;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            lfsr       <= LFSR_W'(LFSR_SEED);
            otp_q      <= 1'b0;
            usr_q      <= 1'b0;
            otp        <= '0;
            otp_valid  <= 1'b0;
            entry      <= '0;
            cnt        <= '0;
            lock_cnt   <= '0;
            tries_left <= TW'(MAX_TRIES);
            auth_pass  <= 1'b0;
            auth_fail  <= 1'b0;
            locked     <= 1'b0;
        end else begin
            lfsr <= lfsr[0] ? ({1'b0, lfsr[LFSR_W-1:1]} ^ TAPS)
                            : {1'b0, lfsr[LFSR_W-1:1]};
            otp_q      <= otp_latch;
            usr_q      <= user_latch;
            tries_left <= tries_d;
            auth_pass  <= pass_d;
            auth_fail  <= miss;
            locked     <= (state_d == LOCK);
            lock_cnt   <= (state == LOCK) ? lock_cnt + LW'(1) : '0;
            if (cap) begin
                otp       <= lfsr[CW-1:0];
                otp_valid <= 1'b1;
            end else if (inval) begin
                otp_valid <= 1'b0;
            end
            if (cap || clr) begin
                entry <= '0;
                cnt   <= '0;
            end else if (take) begin
                entry[IW'(cnt)] <= user_in;
                cnt             <= cnt + NW'(1);
            end
        end
    end

    otp_seg7_dec u_dec_otp (
        .digit (otp[idx]),
        .seg   (otp_seg)
    );

    otp_seg7_dec u_dec_usr (
        .digit (entry[idx]),
        .seg   (usr_seg)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            scan_cnt <= '0;
            idx      <= '0;
            an       <= NUM_DIGITS'(1);
            lfsr_out <= 7'h00;
            user_out <= 7'h00;
        end else begin
            if (scan_cnt == SW'(SCAN_DIV - 1)) begin
                scan_cnt <= '0;
                an       <= {an[NUM_DIGITS-2:0], an[NUM_DIGITS-1]};
                idx      <= (idx == IW'(NUM_DIGITS - 1)) ? '0
                                                         : idx + IW'(1);
            end else begin
                scan_cnt <= scan_cnt + SW'(1);
            end
            lfsr_out <= otp_valid ? otp_seg : 7'h00;
            user_out <= (NW'(idx) < cnt) ? usr_seg : 7'h00;
        end
    end

endmodule

// File: tb/tb_otp_auth_multi.sv
// tb_otp_auth_multi: self-checking bench for otp_auth_multi.
// Scoreboard of expected pass/fail pulses plus display and lockout checks.
module tb_otp_auth_multi;

    logic       clk;
    logic       reset;
    logic       otp_latch;
    logic       user_latch;
    logic [3:0] user_in;
    logic [6:0] lfsr_out;
    logic [6:0] user_out;
    logic [3:0] an;
    logic       auth_pass;
    logic       auth_fail;
    logic       locked;
    logic [1:0] tries_left;

    otp_auth_multi dut (
        .clk        (clk),
        .reset      (reset),
        .otp_latch  (otp_latch),
        .user_latch (user_latch),
        .user_in    (user_in),
        .lfsr_out   (lfsr_out),
        .user_out   (user_out),
        .an         (an),
        .auth_pass  (auth_pass),
        .auth_fail  (auth_fail),
        .locked     (locked),
        .tries_left (tries_left)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit pass;
        int tries;
        int at;
    } exp_t;

    exp_t        sbq[$];
    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    int          lock_seen = 0;
    logic [15:0] m_lfsr = 16'h0;
    logic [15:0] m_otp = 16'h0;
    logic [15:0] m_entry = 16'h0;
    bit          m_valid = 0;
    int          m_cnt = 0;
    int          m_tries = 3;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h @cyc%0d", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [6:0] seg(input logic [3:0] d);
        case (d)
            4'h0: return 7'h3F;  4'h1: return 7'h06;
            4'h2: return 7'h5B;  4'h3: return 7'h4F;
            4'h4: return 7'h66;  4'h5: return 7'h6D;
            4'h6: return 7'h7D;  4'h7: return 7'h07;
            4'h8: return 7'h7F;  4'h9: return 7'h6F;
            4'hA: return 7'h77;  4'hB: return 7'h7C;
            4'hC: return 7'h39;  4'hD: return 7'h5E;
            4'hE: return 7'h79;  default: return 7'h71;
        endcase
    endfunction

    // reference Galois LFSR, x^16+x^14+x^13+x^11+1
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (reset) m_lfsr <= 16'hACE1;
        else m_lfsr <= {1'b0, m_lfsr[15:1]} ^ (m_lfsr[0] ? 16'hB400 : 16'h0);
    end

    always @(negedge clk) begin
        exp_t e;
        if (!reset && (auth_pass || auth_fail)) begin
            if (sbq.size() == 0) begin
                chk("unexp_pulse", {auth_pass, auth_fail}, 0);
            end else begin
                e = sbq.pop_front();
                chk("pulse_kind", {auth_pass, auth_fail},
                    e.pass ? 2'b10 : 2'b01);
                if (e.at >= 0) chk("pulse_cyc", cyc, e.at);
                chk("pulse_tries", tries_left, e.tries);
            end
        end
        if (locked) lock_seen++;
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic press_otp();
        m_otp = m_lfsr;
        m_valid = 1;
        m_cnt = 0;
        m_entry = '0;
        otp_latch = 1'b1;
        tick(1);
        otp_latch = 1'b0;
        tick(1);
    endtask

    task automatic raw_press(input bit o, input bit u, input logic [3:0] d);
        user_in = d;
        otp_latch = o;
        user_latch = u;
        tick(1);
        otp_latch = 1'b0;
        user_latch = 1'b0;
        tick(1);
    endtask

    task automatic key(input logic [3:0] d);
        exp_t e;
        m_entry[m_cnt*4 +: 4] = d;
        m_cnt++;
        if (m_cnt == 4) begin
            e.pass = (m_entry == m_otp);
            e.at = cyc + 2;
            if (e.pass) begin
                e.tries = 3;
                m_valid = 0;
            end else begin
                e.tries = m_tries - 1;
                if (e.tries > 0) begin
                    m_cnt = 0;
                    m_entry = '0;
                end
            end
            m_tries = e.tries;
            sbq.push_back(e);
        end
        raw_press(1'b0, 1'b1, d);
    endtask

    task automatic enter(input logic [15:0] code);
        for (int i = 0; i < 4; i++) key(code[i*4 +: 4]);
        tick(4);
    endtask

    task automatic scan_chk(input string tag);
        logic [3:0] a0;
        int n;
        int ix;
        for (int p = 0; p < 4; p++) begin
            a0 = an;
            n = 0;
            while (an == a0 && n < 40) begin
                tick(1);
                n++;
            end
            tick(2);
            ix = 0;
            for (int b = 0; b < 4; b++) if (an[b]) ix = b;
            chk({tag, "_step"}, n < 40, 1);
            chk({tag, "_onehot"}, $countones(an), 1);
            chk({tag, "_otpseg"}, lfsr_out,
                m_valid ? seg(m_otp[ix*4 +: 4]) : 7'h00);
            chk({tag, "_usrseg"}, user_out,
                (ix < m_cnt) ? seg(m_entry[ix*4 +: 4]) : 7'h00);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_an"}, an, 4'b0001);
        chk({tag, "_lfsr_out"}, lfsr_out, 7'h00);
        chk({tag, "_user_out"}, user_out, 7'h00);
        chk({tag, "_pass"}, auth_pass, 1'b0);
        chk({tag, "_fail"}, auth_fail, 1'b0);
        chk({tag, "_locked"}, locked, 1'b0);
        chk({tag, "_tries"}, tries_left, 2'd3);
    endtask

    initial begin
        int n;
        reset = 1'b1;
        otp_latch = 1'b0;
        user_latch = 1'b0;
        user_in = 4'h0;
        tick(2);
        chk_reset_vals("rst");
        reset = 1'b0;
        tick(15);
        chk("rst_an_hold", an, 4'b0001);
        tick(1);
        chk("rst_an_rot", an, 4'b0010);

        raw_press(1'b0, 1'b1, 4'h7);
        scan_chk("idle_usr");

        press_otp();
        scan_chk("otp_shown");
        enter(m_otp);
        chk("pass_tries", tries_left, 2'd3);
        scan_chk("after_pass");

        press_otp();
        enter(~m_otp);
        chk("fail1_tries", tries_left, 2'd2);
        chk("fail1_nolock", locked, 1'b0);
        enter(~m_otp);
        chk("fail2_tries", tries_left, 2'd1);
        lock_seen = 0;
        enter(~m_otp);
        chk("fail3_tries", tries_left, 2'd0);
        chk("fail3_locked", locked, 1'b1);
        raw_press(1'b1, 1'b0, 4'h1);
        raw_press(1'b0, 1'b1, 4'h2);
        n = 0;
        while (locked && n < 1200) begin
            tick(1);
            n++;
        end
        chk("lock_len", lock_seen, 1024);
        chk("unlock_tries", tries_left, 2'd3);
        m_valid = 0;
        m_tries = 3;
        tick(2);
        scan_chk("post_lock");

        press_otp();
        key(m_otp[3:0]);
        key(m_otp[7:4]);
        scan_chk("two_dig");
        press_otp();
        scan_chk("restart");
        m_otp = m_lfsr;
        raw_press(1'b1, 1'b1, 4'h9);
        enter(m_otp);

        press_otp();
        user_in = m_otp[3:0];
        user_latch = 1'b1;
        tick(10);
        user_latch = 1'b0;
        tick(1);
        m_entry[3:0] = m_otp[3:0];
        m_cnt = 1;
        scan_chk("hold");
        key(m_otp[7:4]);
        key(m_otp[11:8]);
        key(m_otp[15:12]);
        tick(4);

`ifdef OTP_TIMEOUT_EN
        begin
            exp_t e;
            press_otp();
            e.pass = 0;
            e.tries = m_tries - 1;
            e.at = -1;
            m_tries = e.tries;
            sbq.push_back(e);
            n = 0;
            while (sbq.size() != 0 && n < 4300) begin
                tick(1);
                n++;
            end
            chk("timeout_seen", sbq.size(), 0);
            chk("timeout_tries", tries_left, 2'd2);
        end
`endif

        press_otp();
        key(m_otp[3:0]);
        key(m_otp[7:4]);
        reset = 1'b1;
        tick(1);
        chk_reset_vals("mid_rst");
        reset = 1'b0;
        m_valid = 0;
        m_cnt = 0;
        m_entry = '0;
        m_tries = 3;
        raw_press(1'b0, 1'b1, 4'h5);
        scan_chk("rst_idle");
        press_otp();
        enter(m_otp);

        tick(5);
        chk("sb_empty", sbq.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog expired got=running exp=finished");
        $fatal(1, "watchdog");
    end

endmodule
